// File: rtl/core_pcseq_pkg.sv
// Shared definitions for the program-counter sequencer: mode encodings,
// enable constants and the stack-occupancy width helper.
package core_pcseq_pkg;

  typedef enum logic [2:0] {
    PCS_HOLD     = 3'd0,
    PCS_INC      = 3'd1,
    PCS_REL      = 3'd2,
    PCS_DIR      = 3'd3,
    PCS_CALL_REL = 3'd4,
    PCS_CALL_DIR = 3'd5,
    PCS_RET      = 3'd6,
    PCS_INT      = 3'd7
  } pcs_mode_e;

  localparam logic EN  = 1'b1;
  localparam logic DIS = 1'b0;

  // Bits needed to count 0..depth inclusive.
  function automatic int pcs_depth_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/core_pcseq_stack.sv
// Return-address LIFO, PC_W x STACK_DEPTH, state on the falling edge of i_clk.
// PCS_STACK_WRAP_EN makes it circular: a push when full overwrites the oldest entry.
module core_pcseq_stack
  import core_pcseq_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_W     = pcs_depth_w(STACK_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [PC_W-1:0]    i_push_dat,
  output logic [PC_W-1:0]    o_top,
  output logic               o_full,
  output logic               o_empty,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_ovf,
  output logic               o_unf
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(STACK_DEPTH - 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  logic [PC_W-1:0]    r_mem [STACK_DEPTH];
  logic [PTR_W-1:0]   r_ptr;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_full;
  logic               r_empty;

  logic [PTR_W-1:0]   w_ptr_inc;
  logic [PTR_W-1:0]   w_ptr_dec;
  logic [DEPTH_W-1:0] w_depth_nxt;
  logic               w_do_push;
  logic               w_do_pop;

  // r_ptr is the next free slot; the top entry sits one slot below it.
  assign w_ptr_inc = (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
  assign w_ptr_dec = (r_ptr == '0) ? PTR_LAST : r_ptr - PTR_W'(1);

`ifdef PCS_STACK_WRAP_EN
  assign w_do_push = i_push;
  assign o_ovf     = 1'b0;
`else
  assign w_do_push = i_push & ~r_full;
  assign o_ovf     = i_push & r_full;
`endif
  assign w_do_pop  = i_pop & ~r_empty;
  assign o_unf     = i_pop & r_empty;

  always_comb begin
    w_depth_nxt = r_depth;
    if (w_do_push) begin
      if (!r_full) w_depth_nxt = r_depth + DEPTH_W'(1);
    end else if (w_do_pop) begin
      w_depth_nxt = r_depth - DEPTH_W'(1);
    end
  end

  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_depth <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_do_push)     r_ptr <= w_ptr_inc;
      else if (w_do_pop) r_ptr <= w_ptr_dec;
      r_depth <= w_depth_nxt;
      r_full  <= (w_depth_nxt == DEPTH_MAX);
      r_empty <= (w_depth_nxt == '0);
    end
  end

  // Contents need no reset; occupancy alone defines validity.
  always_ff @(negedge i_clk) begin
    if (!i_rst && w_do_push) r_mem[r_ptr] <= i_push_dat;
  end

  assign o_top   = r_mem[w_ptr_dec];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_depth = r_depth;

endmodule

// File: rtl/core_pcseq.sv
// Program-counter sequencer: next-PC mux/adder, return stack, sticky stack error.
// PC registered on the falling edge; PCS_STACK_WRAP_EN selects a circular stack.
module core_pcseq
  import core_pcseq_pkg::*;
#(
  parameter int              PC_W         = 16,
  parameter int              OFS_W        = 8,
  parameter int              STACK_DEPTH  = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter logic [PC_W-1:0] INT_VECTOR   = PC_W'(16'h0004)
) (
  input  logic                                 pcs_clock_mem_i,
  input  logic                                 pcs_reset_i,
  input  logic                                 pcs_en_i,
  input  logic [2:0]                           pcs_mode_i,
  input  logic [OFS_W-1:0]                     pcs_offset_i,
  input  logic [PC_W-OFS_W-1:0]                pcs_pc_msb_i,
  output logic [PC_W-1:0]                      pcs_pc_o,
  output logic                                 pcs_stack_full_o,
  output logic                                 pcs_stack_empty_o,
  output logic                                 pcs_stack_err_o,
  output logic [pcs_depth_w(STACK_DEPTH)-1:0]  pcs_depth_o
);

  localparam int DEPTH_W = pcs_depth_w(STACK_DEPTH);

  logic [PC_W-1:0] r_pc;
  logic            r_err;

  logic [PC_W-1:0] w_rel;
  logic [PC_W-1:0] w_dir;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_top;
  logic            w_push;
  logic            w_pop;
  logic            w_ovf;
  logic            w_unf;
  logic            w_step;

  assign w_step = (pcs_en_i == EN);
  assign w_rel  = r_pc + {{(PC_W-OFS_W){pcs_offset_i[OFS_W-1]}}, pcs_offset_i};
  assign w_dir  = {pcs_pc_msb_i, pcs_offset_i};

  always_comb begin
    w_target = r_pc;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    case (pcs_mode_e'(pcs_mode_i))
      PCS_HOLD:     w_target = r_pc;
      PCS_INC:      w_target = r_pc + PC_W'(1);
      PCS_REL:      w_target = w_rel;
      PCS_DIR:      w_target = w_dir;
      PCS_CALL_REL: begin w_target = w_rel;      w_push = w_step; end
      PCS_CALL_DIR: begin w_target = w_dir;      w_push = w_step; end
      PCS_RET:      begin w_target = w_top;      w_pop  = w_step; end
      PCS_INT:      begin w_target = INT_VECTOR; w_push = w_step; end
      default:      w_target = r_pc;
    endcase
  end

  // A refused push or pop leaves the PC where it is.
  assign w_pc_next = (w_ovf || w_unf) ? r_pc : w_target;

  core_pcseq_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DEPTH_W)
  ) u_stack (
    .i_clk      (pcs_clock_mem_i),
    .i_rst      (pcs_reset_i),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_push_dat (r_pc),
    .o_top      (w_top),
    .o_full     (pcs_stack_full_o),
    .o_empty    (pcs_stack_empty_o),
    .o_depth    (pcs_depth_o),
    .o_ovf      (w_ovf),
    .o_unf      (w_unf)
  );

  always_ff @(negedge pcs_clock_mem_i) begin
    if (pcs_reset_i) begin
      r_pc  <= RESET_VECTOR;
      r_err <= 1'b0;
    end else if (w_step) begin
      r_pc <= w_pc_next;
      if (w_ovf || w_unf) r_err <= 1'b1;
    end
  end

  assign pcs_pc_o        = r_pc;
  assign pcs_stack_err_o = r_err;

endmodule

// File: tb/tb_core_pcseq.sv
// Directed bench for core_pcseq with default parameters; inputs change and
// outputs are sampled on the rising edge, away from the falling active edge.
module tb_core_pcseq;
  import core_pcseq_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  mode;
  logic [7:0]  ofs;
  logic [7:0]  msb;
  logic [15:0] pc;
  logic        full;
  logic        empty;
  logic        err;
  logic [2:0]  depth;

  int total = 0;
  int bad   = 0;

  core_pcseq dut (
    .pcs_clock_mem_i   (clk),
    .pcs_reset_i       (rst),
    .pcs_en_i          (en),
    .pcs_mode_i        (mode),
    .pcs_offset_i      (ofs),
    .pcs_pc_msb_i      (msb),
    .pcs_pc_o          (pc),
    .pcs_stack_full_o  (full),
    .pcs_stack_empty_o (empty),
    .pcs_stack_err_o   (err),
    .pcs_depth_o       (depth)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Apply one step, let the falling edge commit it, return at the next rising edge.
  task automatic step(input logic [2:0] m, input logic [15:0] arg,
                      input logic e, input logic r);
    mode = m;
    msb  = arg[15:8];
    ofs  = arg[7:0];
    en   = e;
    rst  = r;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'd0; ofs = '0; msb = '0;
    @(posedge clk);

    step(PCS_HOLD, 16'h0000, 1'b1, 1'b1);
    chk("rst_pc", {16'h0, pc}, 32'h0000);
    chk("rst_depth", {29'h0, depth}, 32'd0);
    chk("rst_empty", {31'h0, empty}, 32'd1);
    chk("rst_full", {31'h0, full}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);

    step(PCS_INC, 16'h0000, 1'b1, 1'b0);
    chk("inc1", {16'h0, pc}, 32'h0001);
    step(PCS_INC, 16'h0000, 1'b1, 1'b0);
    chk("inc2", {16'h0, pc}, 32'h0002);
    step(PCS_INC, 16'h0000, 1'b1, 1'b0);
    chk("inc3", {16'h0, pc}, 32'h0003);

    step(PCS_DIR, 16'hFFFF, 1'b1, 1'b0);
    chk("dir_ffff", {16'h0, pc}, 32'hFFFF);
    step(PCS_INC, 16'h0000, 1'b1, 1'b0);
    chk("inc_wrap", {16'h0, pc}, 32'h0000);

    step(PCS_DIR, 16'h00F0, 1'b1, 1'b0);
    step(PCS_REL, 16'h0020, 1'b1, 1'b0);
    chk("rel_pos_carry", {16'h0, pc}, 32'h0110);
    step(PCS_REL, 16'h00E0, 1'b1, 1'b0);
    chk("rel_neg_borrow", {16'h0, pc}, 32'h00F0);

    step(PCS_DIR, 16'h0100, 1'b1, 1'b0);
    step(PCS_CALL_DIR, 16'h1234, 1'b1, 1'b0);
    chk("calldir_pc", {16'h0, pc}, 32'h1234);
    chk("calldir_depth", {29'h0, depth}, 32'd1);
    step(PCS_CALL_REL, 16'h0010, 1'b1, 1'b0);
    chk("callrel_pc", {16'h0, pc}, 32'h1244);
    chk("callrel_depth", {29'h0, depth}, 32'd2);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("ret1_pc", {16'h0, pc}, 32'h1234);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("ret2_pc", {16'h0, pc}, 32'h0100);
    chk("ret2_empty", {31'h0, empty}, 32'd1);

    // Four calls fill the stack with 0100,1000,2000,3000.
    step(PCS_CALL_DIR, 16'h1000, 1'b1, 1'b0);
    step(PCS_CALL_DIR, 16'h2000, 1'b1, 1'b0);
    step(PCS_CALL_DIR, 16'h3000, 1'b1, 1'b0);
    step(PCS_CALL_DIR, 16'h4000, 1'b1, 1'b0);
    chk("fill_full", {31'h0, full}, 32'd1);
    chk("fill_depth", {29'h0, depth}, 32'd4);
    step(PCS_CALL_DIR, 16'h5000, 1'b1, 1'b0);
`ifdef PCS_STACK_WRAP_EN
    chk("ovf_pc", {16'h0, pc}, 32'h5000);
    chk("ovf_err", {31'h0, err}, 32'd0);
    chk("ovf_depth", {29'h0, depth}, 32'd4);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("wret1", {16'h0, pc}, 32'h4000);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("wret2", {16'h0, pc}, 32'h3000);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("wret3", {16'h0, pc}, 32'h2000);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("wret4", {16'h0, pc}, 32'h1000);
    chk("wret_empty", {31'h0, empty}, 32'd1);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("unf_pc", {16'h0, pc}, 32'h1000);
    chk("unf_err", {31'h0, err}, 32'd1);
    step(PCS_INC, 16'h0000, 1'b1, 1'b0);
    chk("err_sticky_pc", {16'h0, pc}, 32'h1001);
`else
    chk("ovf_pc", {16'h0, pc}, 32'h4000);
    chk("ovf_err", {31'h0, err}, 32'd1);
    chk("ovf_full", {31'h0, full}, 32'd1);
    chk("ovf_depth", {29'h0, depth}, 32'd4);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("bret1", {16'h0, pc}, 32'h3000);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("bret2", {16'h0, pc}, 32'h2000);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("bret3", {16'h0, pc}, 32'h1000);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("bret4", {16'h0, pc}, 32'h0100);
    chk("bret_empty", {31'h0, empty}, 32'd1);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("unf_pc", {16'h0, pc}, 32'h0100);
    chk("unf_err", {31'h0, err}, 32'd1);
    step(PCS_INC, 16'h0000, 1'b1, 1'b0);
    chk("err_sticky_pc", {16'h0, pc}, 32'h0101);
`endif
    chk("err_sticky", {31'h0, err}, 32'd1);
    step(PCS_HOLD, 16'h0000, 1'b0, 1'b0);
    chk("err_sticky_dis", {31'h0, err}, 32'd1);
    step(PCS_HOLD, 16'h0000, 1'b0, 1'b1);
    chk("err_cleared", {31'h0, err}, 32'd0);
    chk("err_rst_pc", {16'h0, pc}, 32'h0000);

    step(PCS_DIR, 16'h0300, 1'b1, 1'b0);
    step(PCS_CALL_DIR, 16'h1234, 1'b0, 1'b0);
    chk("dis_pc", {16'h0, pc}, 32'h0300);
    chk("dis_depth", {29'h0, depth}, 32'd0);

    step(PCS_DIR, 16'h0200, 1'b1, 1'b0);
    step(PCS_INT, 16'h0000, 1'b1, 1'b0);
    chk("int_pc", {16'h0, pc}, 32'h0004);
    chk("int_depth", {29'h0, depth}, 32'd1);
    step(PCS_RET, 16'h0000, 1'b1, 1'b0);
    chk("int_ret_pc", {16'h0, pc}, 32'h0200);
    chk("int_ret_depth", {29'h0, depth}, 32'd0);

    step(PCS_CALL_DIR, 16'h1111, 1'b1, 1'b0);
    step(PCS_CALL_DIR, 16'h2222, 1'b1, 1'b0);
    step(PCS_CALL_DIR, 16'h3333, 1'b1, 1'b0);
    chk("d3_depth", {29'h0, depth}, 32'd3);
    step(PCS_HOLD, 16'h0000, 1'b1, 1'b0);
    chk("hold_pc", {16'h0, pc}, 32'h3333);
    step(PCS_CALL_DIR, 16'h4444, 1'b1, 1'b1);
    chk("rst_mid_depth", {29'h0, depth}, 32'd0);
    chk("rst_mid_pc", {16'h0, pc}, 32'h0000);
    chk("rst_mid_empty", {31'h0, empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
